// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA raster timing block.
// Holds the axis segment enum, the default 640x480@60 timing and the
// coordinate/frame-counter widths used by vga_timing_ctrl and vga_axis_fsm.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 16;

  // Default 640x480@60 timing; 100 MHz system clock divided to 25 MHz pixels
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } axis_state_e;

  // Segment order along either axis; BACK loops back to ACTIVE
  function automatic axis_state_e next_seg(input axis_state_e s);
    case (s)
      ST_ACTIVE: return ST_FRONT;
      ST_FRONT:  return ST_SYNC;
      ST_SYNC:   return ST_BACK;
      default:   return ST_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle between the timing controller (master)
// and the pixel/graphics logic (slave). The slave owns the run enable.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic               en;
  logic               pix_tick;
  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  en,
    output pix_tick, h_count, v_count, hsync, vsync,
    output video_on, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  pix_tick, h_count, v_count, hsync, vsync,
    input  video_on, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: one raster axis (horizontal or vertical). Counts position on
// each step and walks ACTIVE -> FRONT -> SYNC -> BACK. Position, state and the
// active-low sync are registered together so they never skew. 'wrap' is the
// combinational carry: high in the cycle whose step takes pos from the last
// position back to 0, so a downstream axis can step on the same clock edge.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int SEG_ACTIVE = DEF_H_ACTIVE,
  parameter int SEG_FRONT  = DEF_H_FP,
  parameter int SEG_SYNC   = DEF_H_SYNC,
  parameter int SEG_BACK   = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COORD_W-1:0] pos,
  output axis_state_e        state,
  output logic               sync_n,
  output logic               wrap
);

  localparam int TOTAL = SEG_ACTIVE + SEG_FRONT + SEG_SYNC + SEG_BACK;

  localparam logic [COORD_W-1:0] LAST_ACTIVE = COORD_W'(SEG_ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_FRONT  = COORD_W'(SEG_ACTIVE + SEG_FRONT - 1);
  localparam logic [COORD_W-1:0] LAST_SYNC   = COORD_W'(SEG_ACTIVE + SEG_FRONT + SEG_SYNC - 1);
  localparam logic [COORD_W-1:0] LAST_BACK   = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] pos_reg, pos_next;
  logic [COORD_W-1:0] seg_last;
  axis_state_e        state_reg, state_next;
  logic               sync_n_reg;

  // Next position/segment: advance only on step, leave a segment from its last position
  always_comb begin
    pos_next   = pos_reg;
    state_next = state_reg;
    case (state_reg)
      ST_ACTIVE: seg_last = LAST_ACTIVE;
      ST_FRONT:  seg_last = LAST_FRONT;
      ST_SYNC:   seg_last = LAST_SYNC;
      default:   seg_last = LAST_BACK;
    endcase
    wrap = step && (pos_reg == LAST_BACK);
    if (step) begin
      pos_next = wrap ? '0 : pos_reg + 1'b1;
      if (pos_reg == seg_last) begin
        state_next = next_seg(state_reg);
      end
    end
  end

  // Axis state register; sync is derived from the next segment so it lines up with pos
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg    <= '0;
      state_reg  <= ST_ACTIVE;
      sync_n_reg <= 1'b1;
    end else begin
      pos_reg    <= pos_next;
      state_reg  <= state_next;
      sync_n_reg <= (state_next != ST_SYNC);
    end
  end

  assign pos    = pos_reg;
  assign state  = state_reg;
  assign sync_n = sync_n_reg;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 VGA raster sequencer. Divides clk into a pixel
// tick, drives the horizontal axis from it and the vertical axis from the
// horizontal wrap, and presents coordinates, syncs, blanking and line/frame
// pulses, all registered so they change on the same edge as the coordinates.
// Build option: define VGA_FRAME_CNT_EN to include the 16-bit frame counter;
// otherwise frame_count is tied to zero.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input logic         clk,
  input logic         rst,
  vga_timing_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_reg;
  logic               step;
  logic               tick_reg;
  logic               started_reg;
  logic               line_reg;
  logic               frame_reg;

  logic [COORD_W-1:0] h_pos, v_pos;
  axis_state_e        h_state, v_state;
  logic               h_sync_n, v_sync_n;
  logic               h_wrap, v_wrap;

  // The pixel step happens on the clock where the divider wraps; en freezes it
  assign step = bus.en && (div_reg == DIV_LAST);

  // Divider and pulse registers; pulses land on the edge the counters move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg     <= '0;
      tick_reg    <= 1'b0;
      started_reg <= 1'b0;
      line_reg    <= 1'b0;
      frame_reg   <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      tick_reg    <= step;
      line_reg    <= h_wrap;
      frame_reg   <= v_wrap;
      if (bus.en) begin
        div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
    end
  end

  vga_axis_fsm #(
    .SEG_ACTIVE(H_ACTIVE),
    .SEG_FRONT (H_FP),
    .SEG_SYNC  (H_SYNC),
    .SEG_BACK  (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (step),
    .pos   (h_pos),
    .state (h_state),
    .sync_n(h_sync_n),
    .wrap  (h_wrap)
  );

  // Vertical axis advances on the same edge the horizontal axis wraps
  vga_axis_fsm #(
    .SEG_ACTIVE(V_ACTIVE),
    .SEG_FRONT (V_FP),
    .SEG_SYNC  (V_SYNC),
    .SEG_BACK  (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (h_wrap),
    .pos   (v_pos),
    .state (v_state),
    .sync_n(v_sync_n),
    .wrap  (v_wrap)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_reg;

  // Count completed frames; the new value appears together with frame_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign bus.frame_count = frame_cnt_reg;
`else
  assign bus.frame_count = '0;
`endif

  // Pulses and blanking are gated by en so a frozen raster shows nothing
  assign bus.pix_tick    = tick_reg && bus.en;
  assign bus.line_start  = line_reg && bus.en;
  assign bus.frame_start = frame_reg && bus.en;
  assign bus.video_on    = started_reg && bus.en &&
                           (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
  assign bus.h_count     = h_pos;
  assign bus.v_count     = v_pos;
  assign bus.hsync       = h_sync_n;
  assign bus.vsync       = v_sync_n;

endmodule
